bp_be_fp_wb_arbiter: RTL

//   Writeback stage for the FP register file, directly downstream of the FMA pipe.

---
 rtl/bp_be_pkg.sv | 24 ++
 rtl/bp_be_fp_wb_tag_chain.sv | 53 +++++
 rtl/bp_be_fp_wb_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/bp_be_pkg.sv
// Shared back-end types for the FP writeback path: boxed datapath width,
// RISC-V fflags layout and the writeback payload carried by the long-latency FIFO.
package bp_be_pkg;

  localparam int dpath_width_gp    = 66;
  localparam int reg_addr_width_gp = 5;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } rv64_fflags_s;

  localparam int fflags_width_gp = $bits(rv64_fflags_s);

  typedef struct packed {
    logic [reg_addr_width_gp-1:0] rd;
    logic [dpath_width_gp-1:0]    data;
    rv64_fflags_s                 fflags;
  } bp_be_fp_wb_s;

endpackage

// File: rtl/bp_be_fp_wb_tag_chain.sv
// Shadow chain of {valid, rd} that tracks FMA ops in flight; flush_i kills the
// youngest flush_depth_p stages (1..fma_latency_p) on the same edge.
module bp_be_fp_wb_tag_chain
  import bp_be_pkg::*;
#(
  parameter int fma_latency_p    = 4,
  parameter int flush_depth_p    = 2,
  parameter int reg_addr_width_p = reg_addr_width_gp
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        issue_v_i,
  input  logic [reg_addr_width_p-1:0] issue_rd_i,
  input  logic                        flush_i,
  output logic                        last_v_o,
  output logic [reg_addr_width_p-1:0] last_rd_o
);

  logic [fma_latency_p-1:0]                       r_v;
  logic [fma_latency_p-1:0][reg_addr_width_p-1:0] r_rd;
  logic [fma_latency_p-1:0]                       w_v_next;

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_v_next    = '0;
    w_v_next[0] = issue_v_i;
    for (int i = 1; i < fma_latency_p; i++) begin
      w_v_next[i] = r_v[i-1];
    end
    // Next-state of the youngest stages is killed: the op issuing now plus those not yet committed.
    for (int i = 0; i < flush_depth_p; i++) begin
      if (flush_i) w_v_next[i] = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (reset_i) r_v <= '0;
    else         r_v <= w_v_next;
  end

  // NOTE: tags are qualified by r_v, so this datapath storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    r_rd[0] <= issue_rd_i;
    for (int i = 1; i < fma_latency_p; i++) begin
      r_rd[i] <= r_rd[i-1];
    end
  end

  assign last_v_o  = r_v[fma_latency_p-1];
  assign last_rd_o = r_rd[fma_latency_p-1];

endmodule

// File: rtl/bp_be_fp_wb_arbiter.sv
// FP register-file writeback: tag-matched FMA results always win; long-latency results
// wait in a small FIFO. Define BP_FP_WB_FFLAGS_ACCUM_EN to make fflags_o a sticky OR.
module bp_be_fp_wb_arbiter
  import bp_be_pkg::*;
#(
  parameter int fma_latency_p    = 4,
  parameter int flush_depth_p    = 2,
  parameter int reg_addr_width_p = reg_addr_width_gp,
  parameter int long_els_p       = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        issue_v_i,
  input  logic [reg_addr_width_p-1:0] issue_rd_i,
  input  logic                        flush_i,
  input  logic                        fma_v_i,
  input  logic [dpath_width_gp-1:0]   fma_data_i,
  input  logic [fflags_width_gp-1:0]  fma_fflags_i,
  input  logic                        long_v_i,
  output logic                        long_ready_o,
  input  logic [reg_addr_width_p-1:0] long_rd_i,
  input  logic [dpath_width_gp-1:0]   long_data_i,
  input  logic [fflags_width_gp-1:0]  long_fflags_i,
  output logic                        frf_w_v_o,
  output logic [reg_addr_width_p-1:0] frf_w_addr_o,
  output logic [dpath_width_gp-1:0]   frf_w_data_o,
  output logic                        fflags_v_o,
  output logic [fflags_width_gp-1:0]  fflags_o,
  output logic                        tag_err_o
);

  localparam int ptr_w_lp = $clog2(long_els_p);

  logic                        w_last_v;
  logic [reg_addr_width_p-1:0] w_last_rd;

  bp_be_fp_wb_tag_chain #(
    .fma_latency_p   (fma_latency_p),
    .flush_depth_p   (flush_depth_p),
    .reg_addr_width_p(reg_addr_width_p)
  ) u_tag_chain (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .issue_v_i (issue_v_i),
    .issue_rd_i(issue_rd_i),
    .flush_i   (flush_i),
    .last_v_o  (w_last_v),
    .last_rd_o (w_last_rd)
  );

  // Long-latency FIFO; pointers carry a wrap bit so full and empty are distinguishable.
  logic [ptr_w_lp:0] r_wptr, r_rptr;
  bp_be_fp_wb_s      r_mem [long_els_p];
  bp_be_fp_wb_s      w_long_in;
  logic              w_full, w_empty, w_enq, w_deq, w_fma_win;

  assign w_full    = (r_wptr[ptr_w_lp] != r_rptr[ptr_w_lp])
                   && (r_wptr[ptr_w_lp-1:0] == r_rptr[ptr_w_lp-1:0]);
  assign w_empty   = (r_wptr == r_rptr);
  assign w_fma_win = fma_v_i & w_last_v;
  assign w_enq     = long_v_i & ~w_full;
  assign w_deq     = ~w_empty & ~w_fma_win;
  assign w_long_in = '{rd: long_rd_i, data: long_data_i, fflags: rv64_fflags_s'(long_fflags_i)};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + (ptr_w_lp+1)'(1);
      if (w_deq) r_rptr <= r_rptr + (ptr_w_lp+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr[ptr_w_lp-1:0]] <= w_long_in;
  end

  bp_be_fp_wb_s w_wb;
  logic         w_wb_v;

  always_comb begin
    w_wb   = '0;
    w_wb_v = 1'b0;
    if (w_fma_win) begin
      w_wb_v = 1'b1;
      w_wb   = '{rd: w_last_rd, data: fma_data_i, fflags: rv64_fflags_s'(fma_fflags_i)};
    end else if (w_deq) begin
      w_wb_v = 1'b1;
      w_wb   = r_mem[r_rptr[ptr_w_lp-1:0]];
    end
  end

  logic                        r_frf_w_v, r_fflags_v, r_tag_err;
  logic [reg_addr_width_p-1:0] r_frf_w_addr;
  logic [dpath_width_gp-1:0]   r_frf_w_data;
  logic [fflags_width_gp-1:0]  r_fflags;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_frf_w_v    <= 1'b0;
      r_fflags_v   <= 1'b0;
      r_tag_err    <= 1'b0;
      r_frf_w_addr <= '0;
      r_frf_w_data <= '0;
      r_fflags     <= '0;
    end else begin
      r_frf_w_v  <= w_wb_v;
      r_fflags_v <= w_wb_v;
      if (w_wb_v) begin
        r_frf_w_addr <= w_wb.rd;
        r_frf_w_data <= w_wb.data;
      end
`ifdef BP_FP_WB_FFLAGS_ACCUM_EN
      if (w_wb_v) r_fflags <= r_fflags | w_wb.fflags;
`else
      r_fflags <= w_wb_v ? w_wb.fflags : '0;
`endif
      // A live tag with no matching result means the pipe and the chain disagree.
      if (w_last_v && !fma_v_i) r_tag_err <= 1'b1;
    end
  end

  assign long_ready_o = ~w_full;
  assign frf_w_v_o    = r_frf_w_v;
  assign frf_w_addr_o = r_frf_w_addr;
  assign frf_w_data_o = r_frf_w_data;
  assign fflags_v_o   = r_fflags_v;
  assign fflags_o     = r_fflags;
  assign tag_err_o    = r_tag_err;

endmodule
